// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared types and constants for the gate sweep self-test sequencer.
// States, reference truth tables and settle-timer width helper.
package gate_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  // Wide enough to hold SETTLE itself, never narrower than one bit.
  function automatic int tmr_w(input int settle);
    return $clog2(settle + 2);
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl_timer.sv
// Loadable settle down-counter for the gate sweep sequencer.
// Expires while the count sits at 1; stops at 0.
module sweep_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive input sweep of one combinational gate vs. a truth table.
// Option: GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_sweep_ctrl
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter int                    SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]  EXP_TT = TT_NAND
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] vec_idx,
  output logic [N_IN-1:0] fail_vec
);

  localparam int TW = tmr_w(SETTLE);
  localparam logic [N_IN-1:0] LAST = '1;

  state_t          r_state;
  state_t          w_nxt_state;
  logic [N_IN-1:0] r_vec;
  logic [N_IN-1:0] w_nxt_vec;
  logic [N_IN:0]   r_err;
  logic [N_IN:0]   w_nxt_err;
  logic [N_IN-1:0] r_fail;
  logic [N_IN-1:0] w_nxt_fail;
  logic            r_pass;
  logic            w_nxt_pass;
  logic            r_busy;
  logic            w_nxt_busy;
  logic            r_done;
  logic            w_nxt_done;
  logic            w_load;
  logic            w_expire;
  logic            w_mis;
  logic            w_last;

  sweep_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_value  (TW'(SETTLE)),
    .o_expire (w_expire)
  );

  assign w_mis  = (dut_y != EXP_TT[r_vec]);
  assign w_last = (r_vec == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_err   <= '0;
      r_fail  <= '0;
      r_pass  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_vec   <= w_nxt_vec;
      r_err   <= w_nxt_err;
      r_fail  <= w_nxt_fail;
      r_pass  <= w_nxt_pass;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_vec   = r_vec;
    w_nxt_err   = r_err;
    w_nxt_fail  = r_fail;
    w_nxt_pass  = r_pass;
    w_nxt_busy  = r_busy;
    w_nxt_done  = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_err   = '0;
          w_nxt_fail  = '0;
          w_nxt_pass  = 1'b0;
          w_nxt_vec   = '0;
          w_nxt_busy  = 1'b1;
          w_load      = 1'b1;
          w_nxt_state = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_expire) begin
          w_nxt_state = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (w_mis) begin
          w_nxt_err = r_err + 1'b1;
          if (r_err == '0) begin
            w_nxt_fail = r_vec;
          end
        end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        if (w_mis || w_last) begin
`else
        if (w_last) begin
`endif
          w_nxt_state = S_FIN;
        end else begin
          w_nxt_vec   = r_vec + 1'b1;
          w_load      = 1'b1;
          w_nxt_state = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
        end
      end
      S_FIN: begin
        // done/pass/busy land together on the edge leaving FIN.
        w_nxt_done  = 1'b1;
        w_nxt_pass  = (r_err == '0);
        w_nxt_busy  = 1'b0;
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  assign dut_in   = r_vec;
  assign vec_idx  = r_vec;
  assign err_cnt  = r_err;
  assign fail_vec = r_fail;
  assign pass     = r_pass;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl with NAND / stuck-at GUT models.
// Four instances cover TT_AND and SETTLE values 0, 1 and 3.
module tb_gate_sweep_ctrl;
  import gate_sweep_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start_v = '0;
  logic [3:0] stuck_v = '0;

  logic [1:0] din_a  [4];
  logic       y_a    [4];
  logic       busy_a [4];
  logic       done_a [4];
  logic       pass_a [4];
  logic [2:0] err_a  [4];
  logic [1:0] vec_a  [4];
  logic [1:0] fail_a [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // NAND GUT, optionally stuck-at-1 on its output.
  for (genvar k = 0; k < 4; k++) begin : g_gut
    assign y_a[k] = stuck_v[k] | ~(din_a[k][0] & din_a[k][1]);
  end

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXP_TT(TT_NAND)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .dut_in(din_a[0]),
    .dut_y(y_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .pass(pass_a[0]), .err_cnt(err_a[0]), .vec_idx(vec_a[0]),
    .fail_vec(fail_a[0]));

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXP_TT(TT_AND)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .dut_in(din_a[1]),
    .dut_y(y_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .pass(pass_a[1]), .err_cnt(err_a[1]), .vec_idx(vec_a[1]),
    .fail_vec(fail_a[1]));

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(0), .EXP_TT(TT_NAND)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .dut_in(din_a[2]),
    .dut_y(y_a[2]), .busy(busy_a[2]), .done(done_a[2]),
    .pass(pass_a[2]), .err_cnt(err_a[2]), .vec_idx(vec_a[2]),
    .fail_vec(fail_a[2]));

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(3), .EXP_TT(TT_NAND)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .dut_in(din_a[3]),
    .dut_y(y_a[3]), .busy(busy_a[3]), .done(done_a[3]),
    .pass(pass_a[3]), .err_cnt(err_a[3]), .vec_idx(vec_a[3]),
    .fail_vec(fail_a[3]));

  typedef struct {
    int id;
    int settle;
    int stuck;
    int lat;
    int err;
    int fvec;
    int pass;
    int vmax;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int outs(input int id);
    return {din_a[id], busy_a[id], done_a[id], pass_a[id],
            err_a[id], vec_a[id], fail_a[id]};
  endfunction

  // Start pulse, then watch latency, vector sequence and final results.
  task automatic run(input vec_t r);
    int n;
    int bad;
    int ev;
    bit got;
    stuck_v[r.id] = r.stuck[0];
    @(negedge clk);
    start_v[r.id] = 1'b1;
    @(posedge clk);
    #1;
    start_v[r.id] = 1'b0;
    n = 0;
    bad = 0;
    got = 1'b0;
    while (n < 200 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (done_a[r.id]) begin
        got = 1'b1;
      end else begin
        ev = n / (r.settle + 1);
        if (ev > r.vmax) ev = r.vmax;
        if (int'(vec_a[r.id]) != ev || int'(din_a[r.id]) != ev ||
            !busy_a[r.id]) bad++;
      end
    end
    chk($sformatf("latency[%0d]", r.id), n, r.lat);
    chk($sformatf("vec_seq[%0d]", r.id), bad, 0);
    chk($sformatf("err_cnt[%0d]", r.id), int'(err_a[r.id]), r.err);
    if (r.err != 0)
      chk($sformatf("fail_vec[%0d]", r.id), int'(fail_a[r.id]), r.fvec);
    chk($sformatf("pass[%0d]", r.id), int'(pass_a[r.id]), r.pass);
    chk($sformatf("busy_end[%0d]", r.id), int'(busy_a[r.id]), 0);
    @(posedge clk);
    #1;
    chk($sformatf("done_pulse[%0d]", r.id), int'(done_a[r.id]), 0);
    stuck_v[r.id] = 1'b0;
  endtask

  initial begin
    int n;
    int dn;
    tbl[0] = '{0, 1, 0, 9, 0, 0, 1, 3};
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    tbl[1] = '{1, 1, 0, 3, 1, 0, 0, 0};
`else
    tbl[1] = '{1, 1, 0, 9, 4, 0, 0, 3};
`endif
    tbl[2] = '{0, 1, 1, 9, 1, 3, 0, 3};
    tbl[3] = '{2, 0, 0, 5, 0, 0, 1, 3};
    tbl[4] = '{3, 3, 0, 17, 0, 0, 1, 3};
    tbl[5] = '{3, 3, 1, 17, 1, 3, 0, 3};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_u0", outs(0), 0);
    chk("reset_outs_u3", outs(3), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // Reset in the middle of the sweep at vector 2.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    n = 0;
    while (n < 40 && vec_a[0] != 2'd2) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_reach_vec2", int'(vec_a[0]), 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_outs", outs(0), 0);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_a[0] || busy_a[0]) dn++;
    end
    chk("mid_rst_no_done", dn, 0);
    run(tbl[0]);

    // Start while busy is ignored; start held across FIN restarts.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    n = 0;
    while (n < 40 && !done_a[0]) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 3) start_v[0] = 1'b1;
      if (n == 4) start_v[0] = 1'b0;
      if (n == 7) start_v[0] = 1'b1;
    end
    chk("busy_start_lat", n, 9);
    chk("first_pass", int'(pass_a[0]), 1);
    stuck_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    chk("restart_busy", int'(busy_a[0]), 1);
    chk("restart_pass_clr", int'(pass_a[0]), 0);
    chk("restart_done_low", int'(done_a[0]), 0);
    n = 0;
    while (n < 40 && !done_a[0]) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("second_lat", n, 9);
    chk("second_err", int'(err_a[0]), 1);
    chk("second_fail", int'(fail_a[0]), 3);
    chk("second_pass", int'(pass_a[0]), 0);
    stuck_v[0] = 1'b0;

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
